// File: rtl/tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
//
// Bit / byte / packet timer for the USB bulk-transfer TX path. Emits one
// shift_en strobe per bit period, a byte_done pulse on the last bit of each
// byte and a pkt_done pulse on the last bit of the programmed packet. pause
// freezes every counter (not just the strobe), so a paused bit still spends
// exactly CLKS_PER_BIT active cycles in total.
//
// Optional feature (compile-time macro TX_TIMER_STUFF_EN):
//   when defined, stuff_req sampled on a shift_en inserts one stuff period
//   (CLKS_PER_BIT active cycles ending in stuff_slot instead of shift_en).
//   When undefined, stuff_req is ignored, stuff_slot is 0 and no stuff flop
//   exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a packet (honoured only while idle, pkt_len != 0)
//   pause      in   freeze all counters while high
//   clear      in   synchronous abort to idle, highest priority after rst
//   pkt_len    in   [LEN_W] byte count, latched on an accepted start
//   stuff_req  in   request a stuff period after the current bit
//   shift_en   out  strobe at the end of each data bit period
//   byte_done  out  pulse with the last shift_en of a byte
//   pkt_done   out  pulse with the last byte_done of the packet
//   stuff_slot out  strobe at the end of a stuff period
//   busy       out  high while a packet is in progress (RUN or HOLD)
//   bit_idx    out  [$clog2(BITS_PER_BYTE)] bit index within the byte
//   byte_cnt   out  [LEN_W] bytes completed in this packet
// -----------------------------------------------------------------------------
module tx_bit_timer #(
    parameter int  CLKS_PER_BIT  = 8,
    parameter int  BITS_PER_BYTE = 8,
    parameter int  LEN_W         = 7,
    localparam int BIT_W         = $clog2(BITS_PER_BYTE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic             stuff_req,
    output logic             shift_en,
    output logic             byte_done,
    output logic             pkt_done,
    output logic             stuff_slot,
    output logic             busy,
    output logic [BIT_W-1:0] bit_idx,
    output logic [LEN_W-1:0] byte_cnt
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] clk_cnt_r, clk_cnt_s;
    logic [BIT_W-1:0] bit_idx_r, bit_idx_s;
    logic [LEN_W-1:0] byte_cnt_r, byte_cnt_s;
    logic [LEN_W-1:0] len_q_r, len_q_s;

    logic active_s;
    logic period_end_s;
    logic stuff_cur_s;
    logic shift_en_s;
    logic stuff_slot_s;
    logic byte_done_s;
    logic pkt_done_s;

`ifdef TX_TIMER_STUFF_EN
    // High for the whole of a stuff period.
    logic stuff_r, stuff_s;
    assign stuff_cur_s = stuff_r;
`else
    logic unused_stuff_req_s;
    assign stuff_cur_s        = 1'b0;
    assign unused_stuff_req_s = stuff_req;
`endif

    // Strobe decode: combinational from registered state plus pause/clear,
    // so a pause or clear in the final cycle of a period suppresses its strobe.
    always_comb begin
        active_s     = (state_r == ST_RUN) && !pause && !clear;
        period_end_s = active_s && (clk_cnt_r == CNT_LAST);
        shift_en_s   = period_end_s && !stuff_cur_s;
        stuff_slot_s = period_end_s && stuff_cur_s;
        byte_done_s  = shift_en_s && (bit_idx_r == BIT_LAST);
        pkt_done_s   = byte_done_s && ((byte_cnt_r + LEN_W'(1)) == len_q_r);
    end

    // Next-state and counter update; everything holds unless explicitly changed.
    always_comb begin
        state_s    = state_r;
        clk_cnt_s  = clk_cnt_r;
        bit_idx_s  = bit_idx_r;
        byte_cnt_s = byte_cnt_r;
        len_q_s    = len_q_r;
`ifdef TX_TIMER_STUFF_EN
        stuff_s    = stuff_r;
`endif
        if (clear) begin
            state_s    = ST_IDLE;
            clk_cnt_s  = {CNT_W{1'b0}};
            bit_idx_s  = {BIT_W{1'b0}};
            byte_cnt_s = {LEN_W{1'b0}};
            len_q_s    = {LEN_W{1'b0}};
`ifdef TX_TIMER_STUFF_EN
            stuff_s    = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (pkt_len != {LEN_W{1'b0}})) begin
                        state_s    = ST_RUN;
                        len_q_s    = pkt_len;
                        clk_cnt_s  = {CNT_W{1'b0}};
                        bit_idx_s  = {BIT_W{1'b0}};
                        byte_cnt_s = {LEN_W{1'b0}};
`ifdef TX_TIMER_STUFF_EN
                        stuff_s    = 1'b0;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_s = ST_HOLD;
                    end else if (period_end_s) begin
                        clk_cnt_s = {CNT_W{1'b0}};
                        if (stuff_cur_s) begin
                            // Stuff period: bit and byte position do not move.
                            state_s = ST_RUN;
`ifdef TX_TIMER_STUFF_EN
                            stuff_s = 1'b0;
`endif
                        end else begin
`ifdef TX_TIMER_STUFF_EN
                            // No stuff bit after the final bit of the packet.
                            stuff_s = stuff_req && !pkt_done_s;
`endif
                            if (byte_done_s) begin
                                bit_idx_s  = {BIT_W{1'b0}};
                                byte_cnt_s = byte_cnt_r + LEN_W'(1);
                            end else begin
                                bit_idx_s = bit_idx_r + BIT_W'(1);
                            end
                            if (pkt_done_s) begin
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end
                    end else begin
                        clk_cnt_s = clk_cnt_r + CNT_W'(1);
                        state_s   = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (pause) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            clk_cnt_r  <= {CNT_W{1'b0}};
            bit_idx_r  <= {BIT_W{1'b0}};
            byte_cnt_r <= {LEN_W{1'b0}};
            len_q_r    <= {LEN_W{1'b0}};
`ifdef TX_TIMER_STUFF_EN
            stuff_r    <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            clk_cnt_r  <= clk_cnt_s;
            bit_idx_r  <= bit_idx_s;
            byte_cnt_r <= byte_cnt_s;
            len_q_r    <= len_q_s;
`ifdef TX_TIMER_STUFF_EN
            stuff_r    <= stuff_s;
`endif
        end
    end

    assign shift_en   = shift_en_s;
    assign byte_done  = byte_done_s;
    assign pkt_done   = pkt_done_s;
    assign stuff_slot = stuff_slot_s;
    assign busy       = (state_r != ST_IDLE);
    assign bit_idx    = bit_idx_r;
    assign byte_cnt   = byte_cnt_r;

endmodule

// File: tb/tb_tx_bit_timer.sv
// Bench for tx_bit_timer. Two instances share the control inputs: index 0
// uses default parameters, index 1 uses CLKS_PER_BIT=4, BITS_PER_BYTE=10,
// LEN_W=4. A cycle-level model tracks, per instance, how many active cycles,
// bit periods and stuff periods have elapsed and derives every output from
// those counts; it is compared against both instances on each falling edge.
module tb_tx_bit_timer;

    localparam int CPB_A = 8;
    localparam int BPB_A = 8;
    localparam int CPB_B = 4;
    localparam int BPB_B = 10;
`ifdef TX_TIMER_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       stuff_req = 1'b0;
    logic [6:0] len_a = 7'd0;
    logic [3:0] len_b = 4'd0;

    logic [1:0] shift_v, bdone_v, pdone_v, sslot_v, busy_v;
    logic [2:0] bi_a;
    logic [3:0] bi_b;
    logic [6:0] bc_a;
    logic [3:0] bc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_bit_timer #(.CLKS_PER_BIT(CPB_A), .BITS_PER_BYTE(BPB_A), .LEN_W(7)) u_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .pkt_len(len_a), .stuff_req(stuff_req),
        .shift_en(shift_v[0]), .byte_done(bdone_v[0]), .pkt_done(pdone_v[0]),
        .stuff_slot(sslot_v[0]), .busy(busy_v[0]), .bit_idx(bi_a), .byte_cnt(bc_a)
    );

    tx_bit_timer #(.CLKS_PER_BIT(CPB_B), .BITS_PER_BYTE(BPB_B), .LEN_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .pkt_len(len_b), .stuff_req(stuff_req),
        .shift_en(shift_v[1]), .byte_done(bdone_v[1]), .pkt_done(pdone_v[1]),
        .stuff_slot(sslot_v[1]), .busy(busy_v[1]), .bit_idx(bi_b), .byte_cnt(bc_b)
    );

    // ---------------- model ----------------
    int m_k[2]   = '{0, 0};   // active cycles in this packet
    int m_p[2]   = '{0, 0};   // bit periods completed (data + stuff)
    int m_s[2]   = '{0, 0};   // stuff periods completed
    int m_len[2] = '{0, 0};
    bit m_run[2] = '{1'b0, 1'b0};
    bit m_hold[2] = '{1'b0, 1'b0};
    bit m_stf[2] = '{1'b0, 1'b0};  // current period is a stuff period

    function automatic int cpb(input int d);
        return (d == 0) ? CPB_A : CPB_B;
    endfunction
    function automatic int bpb(input int d);
        return (d == 0) ? BPB_A : BPB_B;
    endfunction
    function automatic int lenv(input int d);
        return (d == 0) ? int'(len_a) : int'(len_b);
    endfunction
    function automatic int obs_bi(input int d);
        return (d == 0) ? int'(bi_a) : int'(bi_b);
    endfunction
    function automatic int obs_bc(input int d);
        return (d == 0) ? int'(bc_a) : int'(bc_b);
    endfunction

    function automatic bit f_act(input int d);
        return m_run[d] && !m_hold[d] && !pause && !clear;
    endfunction
    function automatic bit f_pe(input int d);
        return f_act(d) && ((m_k[d] % cpb(d)) == cpb(d) - 1);
    endfunction
    function automatic bit f_sh(input int d);
        return f_pe(d) && !m_stf[d];
    endfunction
    function automatic bit f_ss(input int d);
        return f_pe(d) && m_stf[d];
    endfunction
    function automatic int f_bits(input int d);
        return m_p[d] - m_s[d];
    endfunction
    function automatic bit f_bd(input int d);
        return f_sh(d) && ((f_bits(d) % bpb(d)) == bpb(d) - 1);
    endfunction
    function automatic bit f_pd(input int d);
        return f_bd(d) && (f_bits(d) + 1 == m_len[d] * bpb(d));
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst || clear) begin
                m_run[d] <= 1'b0; m_hold[d] <= 1'b0; m_stf[d] <= 1'b0;
                m_k[d] <= 0; m_p[d] <= 0; m_s[d] <= 0;
            end else if (!m_run[d]) begin
                if (start && lenv(d) != 0) begin
                    m_run[d] <= 1'b1; m_hold[d] <= 1'b0; m_stf[d] <= 1'b0;
                    m_k[d] <= 0; m_p[d] <= 0; m_s[d] <= 0;
                    m_len[d] <= lenv(d);
                end
            end else if (f_pd(d)) begin
                m_run[d] <= 1'b0; m_hold[d] <= 1'b0; m_stf[d] <= 1'b0;
                m_p[d] <= m_p[d] + 1;
            end else begin
                m_hold[d] <= pause;
                if (f_act(d)) begin
                    m_k[d] <= m_k[d] + 1;
                    if (f_pe(d)) begin
                        m_p[d] <= m_p[d] + 1;
                        if (m_stf[d]) begin
                            m_s[d]   <= m_s[d] + 1;
                            m_stf[d] <= 1'b0;
                        end else begin
                            m_stf[d] <= STUFF_ON && stuff_req;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                check((d == 0) ? "model_a" : "model_b",
                      int'({busy_v[d], shift_v[d], bdone_v[d], pdone_v[d], sslot_v[d],
                            8'(obs_bi(d)), 8'(obs_bc(d))}),
                      int'({m_run[d], f_sh(d), f_bd(d), f_pd(d), f_ss(d),
                            8'(f_bits(d) % bpb(d)), 8'(f_bits(d) / bpb(d))}));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Start is high for one cycle; on return we are 1 time unit into the
    // cycle after the start cycle.
    task automatic do_start(input int la, input int lb);
        @(posedge clk); #1;
        start = 1'b1; len_a = 7'(la); len_b = 4'(lb);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_count(input int d, input int bound,
                             output int first, output int shifts,
                             output int bytes, output int cyc);
        bit done;
        first = 0; shifts = 0; bytes = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (shift_v[d]) begin
                shifts++;
                if (first == 0) first = cyc;
            end
            if (bdone_v[d]) bytes++;
            if (pdone_v[d]) done = 1'b1;
        end
        if (!done) check("pkt_done_timeout", 0, 1);
    endtask

    task automatic wait_shift(input int d, input int bound, output int cyc, output int slots);
        bit done;
        cyc = 0; slots = 0; done = 1'b0;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (sslot_v[d]) slots++;
            if (shift_v[d]) done = 1'b1;
        end
        if (!done) check("shift_timeout", 0, 1);
    endtask

    int f, s, b, c, w, sl, n;
    bit hit;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy_v), 0);
        check("reset_idx", int'(bi_a), 0);
        check("reset_cnt", int'(bc_a), 0);

        // 1: two bytes, no pause
        do_start(2, 1);
        run_count(0, 300, f, s, b, c);
        check("t1_first_shift", f, 8);
        check("t1_shifts", s, 16);
        check("t1_bytes", b, 2);
        check("t1_cycles", c, 128);
        check("t1_busy_at_done", int'(busy_v[0]), 1);
        @(negedge clk);
        check("t1_busy_after", int'(busy_v[0]), 0);
        check("t1_byte_cnt", int'(bc_a), 2);
        repeat (3) @(posedge clk);

        // 2: pause of 5 cycles starting with clk_cnt=3
        do_start(1, 0);
        repeat (3) @(posedge clk);
        #1 pause = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t2_busy_held", int'(busy_v[0]), 1);
        check("t2_idx_held", int'(bi_a), 0);
        check("t2_cnt_held", int'(bc_a), 0);
        @(posedge clk); #1 pause = 1'b0;
        // release cycle is spent leaving HOLD, then 5 active cycles remain
        wait_shift(0, 50, w, sl);
        check("t2_shift_after_release", w, 6);
        check("t2_idx_at_shift", int'(bi_a), 0);
        run_count(0, 200, f, s, b, c);
        check("t2_rest_shifts", s, 7);
        check("t2_rest_bytes", b, 1);
        repeat (3) @(posedge clk);

        // 3: zero length ignored; start while busy ignored
        do_start(0, 0);
        repeat (3) @(negedge clk);
        check("t3_len0_idle", int'(busy_v), 0);
        do_start(2, 2);
        repeat (10) @(posedge clk);
        do_start(5, 5);
        run_count(0, 300, f, s, b, c);
        check("t3_bytes", b, 2);
        @(negedge clk);
        check("t3_final_cnt", int'(bc_a), 2);
        check("t3_idle", int'(busy_v[0]), 0);
        repeat (50) @(posedge clk);

        // 4a: clear on the period end that would carry bit 5 -> 6 of byte 1
        do_start(3, 3);
        hit = 1'b0; n = 0;
        while (!hit && n < 400) begin
            @(negedge clk); n++;
            if (shift_v[0] && bi_a == 3'd4 && bc_a == 7'd1) hit = 1'b1;
        end
        check("t4_reach_idx4", int'(hit), 1);
        repeat (8) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("t4_no_strobe_on_clear", int'({shift_v[0], bdone_v[0], pdone_v[0]}), 0);
        check("t4_idx_before", int'(bi_a), 5);
        check("t4_cnt_before", int'(bc_a), 1);
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("t4_clear_busy", int'(busy_v), 0);
        check("t4_clear_idx", int'(bi_a), 0);
        check("t4_clear_cnt", int'(bc_a), 0);

        // 4b: asynchronous reset mid-byte
        do_start(3, 3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t4_pre_rst_idx", int'(bi_a), 2);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_busy", int'(busy_v), 0);
        check("t4_rst_idx", int'(bi_a), 0);
        check("t4_rst_strobes", int'({shift_v, bdone_v, pdone_v, sslot_v}), 0);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // 5: non-default instance, 15 bytes of 10 bits, 4 clocks per bit
        do_start(0, 15);
        run_count(1, 2000, f, s, b, c);
        check("t5_first_shift", f, 4);
        check("t5_shifts", s, 150);
        check("t5_bytes", b, 15);
        check("t5_cycles", c, 600);
        @(negedge clk);
        check("t5_final_cnt", int'(bc_b), 15);
        repeat (3) @(posedge clk);

        // 6: stuff request on the 3rd shift of instance 0
        do_start(1, 1);
        repeat (23) @(posedge clk);
        #1 stuff_req = 1'b1;
        @(negedge clk);
        check("t6_third_shift", int'(shift_v[0]), 1);
        check("t6_idx_third", int'(bi_a), 2);
        @(posedge clk); #1 stuff_req = 1'b0;
        wait_shift(0, 50, w, sl);
        check("t6_gap_to_fourth", w, STUFF_ON ? 16 : 8);
        check("t6_stuff_slots", sl, STUFF_ON ? 1 : 0);
        check("t6_idx_fourth", int'(bi_a), 3);
        run_count(0, 300, f, s, b, c);
        check("t6_rest_shifts", s, 4);
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
